// File: rtl/mem_trans_pkg.sv
// Shared constants for the transition/power counter memory.
package mem_trans_pkg;

  // Codebase sizing constants.
  localparam int unsigned Ndir       = 3;
  localparam int unsigned NumPwrCntr = 15;

  localparam int unsigned ADDR_W = Ndir + 1;
  localparam int unsigned DEPTH  = NumPwrCntr + 1;
  localparam int unsigned DATA_W = 32;

  // LE encodings for bus direction.
  localparam logic LE_READ  = 1'b1;
  localparam logic LE_WRITE = 1'b0;

endpackage

// File: rtl/mem_trans_iobuf.sv
// Parameterised tri-state driver for the shared data bus.
module mem_trans_iobuf #(
  parameter int unsigned Width = 32
) (
  input  logic             oe,
  input  logic [Width-1:0] dout,
  inout  wire  [Width-1:0] pad
);

  // Release every bit when not enabled so an external master can drive.
  assign pad = oe ? dout : {Width{1'bz}};

endmodule

// File: rtl/mem_trans.sv
// Register file of transition/power counters on a shared bidirectional bus.
// LE=1 reads (block drives dato), LE=0 writes (block samples dato).
// Optional MEMTRANS_INC_EN adds INC: saturating increment of mem[dir] while reading.
module mem_trans #(
  parameter int unsigned ADDR_W = mem_trans_pkg::ADDR_W,
  parameter int unsigned DEPTH  = mem_trans_pkg::DEPTH,
  parameter int unsigned DATA_W = mem_trans_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic [ADDR_W-1:0] dir,
  input  logic              LE,
`ifdef MEMTRANS_INC_EN
  input  logic              INC,
`endif
  inout  wire  [DATA_W-1:0] dato
);

  import mem_trans_pkg::*;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              in_range;
  logic              rd_en;

  assign in_range = (32'(dir) < DEPTH);
  assign rd_en    = (LE == LE_READ);

  // Read mux: out-of-range addresses read as zero, never X.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = mem_q[dir];
    end
  end

  // Next-state: write from the bus, or (optionally) saturating increment on read.
  always_comb begin
    mem_d = mem_q;
    if (!rd_en) begin
      if (in_range) begin
        mem_d[dir] = dato;
      end
    end
`ifdef MEMTRANS_INC_EN
    else if (INC && in_range && !(&mem_q[dir])) begin
      mem_d[dir] = mem_q[dir] + DATA_W'(1);
    end
`endif
  end

  // Counter storage; synchronous reset wins over any write.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  mem_trans_iobuf #(
    .Width(DATA_W)
  ) u_iobuf (
    .oe  (rd_en),
    .dout(rd_data),
    .pad (dato)
  );

endmodule

// File: tb/tb_mem_trans.sv
// Self-checking bench for mem_trans: table-driven write/read vectors with a
// scoreboard queue, plus hand-written sequences for reset, bus release,
// out-of-range access and (with MEMTRANS_INC_EN) saturating increment.
module tb_mem_trans;

  logic        CLK;
  logic        RESET_L;
  logic [3:0]  dir;
  logic        LE;
  logic [31:0] tb_drv;
  logic        tb_oe;
  wire  [31:0] dato;

  // Second instance with a short array for out-of-range checks.
  logic [3:0]  dir2;
  logic        LE2;
  logic [31:0] tb_drv2;
  logic        tb_oe2;
  wire  [31:0] dato2;

`ifdef MEMTRANS_INC_EN
  logic        INC;
  logic        INC2;
`endif

  assign dato  = tb_oe  ? tb_drv  : 32'bz;
  assign dato2 = tb_oe2 ? tb_drv2 : 32'bz;

  mem_trans dut (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .dir    (dir),
    .LE     (LE),
`ifdef MEMTRANS_INC_EN
    .INC    (INC),
`endif
    .dato   (dato)
  );

  mem_trans #(
    .ADDR_W(4),
    .DEPTH (12),
    .DATA_W(32)
  ) dut12 (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .dir    (dir2),
    .LE     (LE2),
`ifdef MEMTRANS_INC_EN
    .INC    (INC2),
`endif
    .dato   (dato2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        le;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [32];
  logic [31:0] sb_q [$];
  int          checks;
  int          failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Pop the oldest expected value and compare against the sampled bus.
  task automatic sb_compare(input string name, input logic [31:0] act);
    logic [31:0] req;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      req = sb_q.pop_front();
      check(name, act, req);
    end
  endtask

  task automatic write1(input logic [3:0] a, input logic [31:0] d);
    LE     = 1'b0;
    dir    = a;
    tb_drv = d;
    tb_oe  = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic read1(input string name, input logic [3:0] a, input logic [31:0] req);
    tb_oe = 1'b0;
    LE    = 1'b1;
    dir   = a;
    sb_q.push_back(req);
    #1;
    sb_compare(name, dato);
  endtask

  task automatic write2(input logic [3:0] a, input logic [31:0] d);
    LE2     = 1'b0;
    dir2    = a;
    tb_drv2 = d;
    tb_oe2  = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic read2(input string name, input logic [3:0] a, input logic [31:0] req);
    tb_oe2 = 1'b0;
    LE2    = 1'b1;
    dir2   = a;
    sb_q.push_back(req);
    #1;
    sb_compare(name, dato2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Vector table: 16 writes of dir*3+7, then 16 readbacks.
    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{le: 1'b0, addr: 4'(i), wdata: 32'(i * 3 + 7), exp: 32'h0};
      vecs[i + 16] = '{le: 1'b1, addr: 4'(i), wdata: 32'h0, exp: 32'(i * 3 + 7)};
    end

    RESET_L = 1'b0;
    LE      = 1'b1;
    dir     = '0;
    tb_drv  = '0;
    tb_oe   = 1'b0;
    LE2     = 1'b1;
    dir2    = '0;
    tb_drv2 = '0;
    tb_oe2  = 1'b0;
`ifdef MEMTRANS_INC_EN
    INC     = 1'b0;
    INC2    = 1'b0;
`endif

    // Reset: one edge low, then every address reads zero.
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read1("reset_read", 4'(i), 32'h0);
    end

    // Table-driven write/readback.
    for (int i = 0; i < 32; i++) begin
      if (vecs[i].le) begin
        read1("wr_readback", vecs[i].addr, vecs[i].exp);
      end else begin
        write1(vecs[i].addr, vecs[i].wdata);
      end
    end

    // Bus release: with LE=0 the bench alone sets the bus (no clock edge here).
    LE     = 1'b0;
    dir    = 4'd5;
    tb_oe  = 1'b1;
    tb_drv = 32'h0000_0000;
    #1;
    check("release_zero", dato, 32'h0000_0000);
    tb_drv = 32'hFFFF_FFFF;
    #1;
    check("release_ones", dato, 32'hFFFF_FFFF);
    // Switch to read without a clock: combinational drive of mem[5].
    tb_oe = 1'b0;
    LE    = 1'b1;
    #1;
    check("le_switch_read", dato, 32'd22);

    // Reset priority over a same-edge write.
    LE      = 1'b0;
    dir     = 4'd3;
    tb_drv  = 32'hDEAD_BEEF;
    tb_oe   = 1'b1;
    RESET_L = 1'b0;
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    read1("reset_prio_dir3", 4'd3, 32'h0);
    read1("reset_clears_dir5", 4'd5, 32'h0);

    // Out-of-range on the 12-deep instance.
    write2(4'd11, 32'h0000_0011);
    write2(4'd13, 32'h0000_0055);
    read2("oor_read13", 4'd13, 32'h0);
    read2("oor_keep11", 4'd11, 32'h0000_0011);
    read2("oor_read12", 4'd12, 32'h0);
    read2("oor_keep0", 4'd0, 32'h0);

`ifdef MEMTRANS_INC_EN
    // Saturating increment: read shows pre-increment value each cycle.
    write1(4'd2, 32'hFFFF_FFFE);
    INC = 1'b1;
    read1("inc_0", 4'd2, 32'hFFFF_FFFE);
    @(posedge CLK);
    #1;
    read1("inc_1", 4'd2, 32'hFFFF_FFFF);
    @(posedge CLK);
    #1;
    read1("inc_2", 4'd2, 32'hFFFF_FFFF);
    @(posedge CLK);
    #1;
    // INC during a write has no effect beyond the write.
    write1(4'd2, 32'h0000_0005);
    read1("inc_ignored_on_write", 4'd2, 32'h0000_0005);
    INC = 1'b0;
`endif

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
